// File: rtl/wf_byte_sdpram_pkg.sv
// Shared types and elaboration helpers for the byte-write simple-dual-port RAM.
//   state_e           : controller states (INIT sweep, RUN)
//   latency_is_legal  : accepted READ_LATENCY values
//   is_pow2_ge2       : depth sanity check
package wf_byte_sdpram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic bit latency_is_legal(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

  function automatic bit is_pow2_ge2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/wf_byte_sdpram_if.sv
// Bus bundle for wf_byte_sdpram.
//   master : user side, drives write/read requests, sees ready/rdata/rvalid
//   slave  : RAM side
// Signals: ready, wen, wAddr[AW], wstrb[DW/8], wdata[DW], ren, rAddr[AW],
//          rdata[DW], rvalid.
interface wf_byte_sdpram_if #(
  parameter int AW = 9,
  parameter int DW = 64
);
  localparam int NB = DW / 8;

  logic          ready;
  logic          wen;
  logic [AW-1:0] wAddr;
  logic [NB-1:0] wstrb;
  logic [DW-1:0] wdata;
  logic          ren;
  logic [AW-1:0] rAddr;
  logic [DW-1:0] rdata;
  logic          rvalid;

  modport master (
    input  ready, rdata, rvalid,
    output wen, wAddr, wstrb, wdata, ren, rAddr
  );

  modport slave (
    output ready, rdata, rvalid,
    input  wen, wAddr, wstrb, wdata, ren, rAddr
  );
endinterface

// File: rtl/wf_byte_sdpram_core.sv
// Plain read-first simple-dual-port RAM with byte write enables, one-cycle
// read latency and no forwarding. Written behaviourally so it maps onto block RAM.
//   clk           : clock
//   we/waddr/wbe/wd : write port (wbe = per-byte enable)
//   re/raddr      : read port
//   rd            : registered read data, updates only when re was high
module wf_byte_sdpram_core #(
  parameter int DEPTH = 512,
  parameter int DW    = 64,
  localparam int AW   = $clog2(DEPTH),
  localparam int NB   = DW / 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [NB-1:0] wbe,
  input  logic [DW-1:0] wd,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rd
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_q;

  // No reset on the array or the read register: block RAM has none, and the
  // top only consumes rd_q on cycles flagged by its own valid pipeline.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (wbe[i]) mem_q[waddr][i*8 +: 8] <= wd[i*8 +: 8];
      end
    end
    if (re) rd_q <= mem_q[raddr];
  end

  assign rd = rd_q;

endmodule

// File: rtl/wf_byte_sdpram.sv
// Byte-write simple-dual-port RAM with per-byte write-first forwarding,
// selectable read latency (1 or 2) and a post-reset clearing sweep.
//   clk, rst : clock, synchronous active-high reset
//   bus      : wf_byte_sdpram_if slave (ready, wen/wAddr/wstrb/wdata,
//              ren/rAddr, rdata/rvalid)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | writes INIT_VALUE to entry cnt each cycle; user port ignored
// ST_RUN  | ready=1, user reads/writes accepted; left only via rst
module wf_byte_sdpram
  import wf_byte_sdpram_pkg::*;
#(
  parameter int                       MY_NUMBER     = 512,
  parameter int                       MY_DATA_WIDTH = 64,
  parameter int                       READ_LATENCY  = 1,
  parameter logic [MY_DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
  input logic             clk,
  input logic             rst,
  wf_byte_sdpram_if.slave bus
);

  localparam int            AW       = $clog2(MY_NUMBER);
  localparam int            DW       = MY_DATA_WIDTH;
  localparam int            NB       = DW / 8;
  localparam logic [AW-1:0] LAST_IDX = AW'(MY_NUMBER - 1);

  if (!latency_is_legal(READ_LATENCY)) begin : g_bad_latency
    $error("wf_byte_sdpram: READ_LATENCY must be 1 or 2");
  end
  if (!is_pow2_ge2(MY_NUMBER)) begin : g_bad_depth
    $error("wf_byte_sdpram: MY_NUMBER must be a power of 2 and >= 2");
  end
  if ((DW % 8) != 0 || DW == 0) begin : g_bad_width
    $error("wf_byte_sdpram: MY_DATA_WIDTH must be a non-zero multiple of 8");
  end

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == LAST_IDX) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Requests count only in RUN and never on a reset edge.
  logic run, wr_acc, rd_acc, coll;
  assign run    = (state_q == ST_RUN);
  assign wr_acc = run & ~rst & bus.wen;
  assign rd_acc = run & ~rst & bus.ren;
  assign coll   = wr_acc & rd_acc & (bus.wAddr == bus.rAddr);

  // Core write port is owned by the init sweep until RUN.
  logic          core_we;
  logic [AW-1:0] core_waddr;
  logic [NB-1:0] core_wbe;
  logic [DW-1:0] core_wd;
  logic [DW-1:0] core_rd;

  always_comb begin
    core_we    = 1'b0;
    core_waddr = bus.wAddr;
    core_wbe   = bus.wstrb;
    core_wd    = bus.wdata;
    if (!rst) begin
      if (state_q == ST_INIT) begin
        core_we    = 1'b1;
        core_waddr = cnt_q;
        core_wbe   = '1;
        core_wd    = INIT_VALUE;
      end else begin
        core_we    = bus.wen;
      end
    end
  end

  wf_byte_sdpram_core #(
    .DEPTH (MY_NUMBER),
    .DW    (DW)
  ) u_core (
    .clk   (clk),
    .we    (core_we),
    .waddr (core_waddr),
    .wbe   (core_wbe),
    .wd    (core_wd),
    .re    (rd_acc),
    .raddr (bus.rAddr),
    .rd    (core_rd)
  );

  // The core is read-first, so a same-cycle write is merged back in per byte.
  // Stage 2 re-times the core output; mask/data follow so writes after the
  // read cycle never leak into the latency-2 result.
  logic          v1_q, v1_d, v2_q, v2_d;
  logic [NB-1:0] mask1_q, mask1_d, mask2_q, mask2_d;
  logic [DW-1:0] fwd1_q, fwd1_d, fwd2_q, fwd2_d;
  logic [DW-1:0] core2_q, core2_d;
  logic [DW-1:0] hold_q, hold_d;

  always_comb begin
    v1_d    = rd_acc;
    mask1_d = coll ? bus.wstrb : '0;
    fwd1_d  = bus.wdata;
    v2_d    = v1_q;
    mask2_d = mask1_q;
    fwd2_d  = fwd1_q;
    core2_d = core_rd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
    end
    mask1_q <= mask1_d;
    fwd1_q  <= fwd1_d;
    mask2_q <= mask2_d;
    fwd2_q  <= fwd2_d;
    core2_q <= core2_d;
  end

  logic          sel_v;
  logic [NB-1:0] sel_mask;
  logic [DW-1:0] sel_fwd, sel_core, merged;

  always_comb begin
    if (READ_LATENCY == 2) begin
      sel_v    = v2_q;
      sel_mask = mask2_q;
      sel_fwd  = fwd2_q;
      sel_core = core2_q;
    end else begin
      sel_v    = v1_q;
      sel_mask = mask1_q;
      sel_fwd  = fwd1_q;
      sel_core = core_rd;
    end
    merged = sel_core;
    for (int i = 0; i < NB; i++) begin
      if (sel_mask[i]) merged[i*8 +: 8] = sel_fwd[i*8 +: 8];
    end
    hold_d = sel_v ? merged : hold_q;
  end

  always_ff @(posedge clk) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end

  // Result is shown in its valid cycle straight from the merge, then held.
  assign bus.rdata  = sel_v ? merged : hold_q;
  assign bus.rvalid = sel_v;
  assign bus.ready  = run;

endmodule
